// File: rtl/output_vc_credit_ctrl.sv
// Per-output-port credit controller: tracks downstream VC credits, masks arbiter requests,
// spends credits on accepted grants and registers the crossbar send strobe.
module output_vc_credit_ctrl #(
    parameter int unsigned V = 4,
    parameter int unsigned B = 4,
    localparam int unsigned CW = $clog2(B + 1),
    localparam int unsigned VW = (V > 1) ? $clog2(V) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [V-1:0]    req_in,
    output logic [V-1:0]    req_out,
    input  logic [V-1:0]    grant,
    input  logic            any_grant,
    input  logic            credit_in_valid,
    input  logic [VW-1:0]   credit_in_vc,
    output logic            send_valid,
    output logic [V-1:0]    send_vc,
    output logic [V*CW-1:0] credit_cnt,
    output logic            all_free,
    output logic            err
);

    localparam logic [CW-1:0] CntMax = CW'(B);

    logic [CW-1:0] cnt_q [V];
    logic [CW-1:0] cnt_d [V];
    logic          send_valid_q;
    logic [V-1:0]  send_vc_q;
    logic          all_free_q, all_free_d;
    logic          err_q, err_d;

    logic          grant_onehot;
    logic          grant_ok;
    logic          vc_ok;
    logic          credit_ok;
    logic          overflow;
    logic [V-1:0]  dec_vec;
    logic [V-1:0]  inc_vec;

    // Masking uses registered counts only, so no grant/credit path reaches req_out.
    always_comb begin
        for (int i = 0; i < V; i++) begin
            req_out[i] = req_in[i] & (cnt_q[i] != '0);
        end
    end

    always_comb begin
        grant_onehot = (grant != '0) && ((grant & (grant - V'(1))) == '0);
        grant_ok     = any_grant && grant_onehot && ((grant & req_out) != '0);
        vc_ok        = 32'(credit_in_vc) < V;
        credit_ok    = credit_in_valid && vc_ok;
        dec_vec      = grant_ok ? grant : '0;
        inc_vec      = credit_ok ? (V'(1) << credit_in_vc) : '0;
    end

    // A return to a full counter is an overflow even when the same VC is spent this cycle.
    always_comb begin
        overflow   = 1'b0;
        all_free_d = 1'b1;
        for (int i = 0; i < V; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && (cnt_q[i] == CntMax)) begin
                overflow = 1'b1;
            end
            if (inc_vec[i] && !dec_vec[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
            if (cnt_d[i] != CntMax) begin
                all_free_d = 1'b0;
            end
        end
    end

    always_comb begin
        err_d = err_q | overflow
              | (any_grant && !grant_ok)
              | (!any_grant && (grant != '0))
              | (credit_in_valid && !vc_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < V; i++) begin
                cnt_q[i] <= CntMax;
            end
            send_valid_q <= 1'b0;
            send_vc_q    <= '0;
            all_free_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < V; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            send_valid_q <= grant_ok;
            send_vc_q    <= dec_vec;
            all_free_q   <= all_free_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < V; i++) begin
            credit_cnt[i*CW +: CW] = cnt_q[i];
        end
    end

    assign send_valid = send_valid_q;
    assign send_vc    = send_vc_q;
    assign all_free   = all_free_q;
    assign err        = err_q;

endmodule

// File: tb/tb_output_vc_credit_ctrl.sv
// Bench for output_vc_credit_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a credit-count model.
module tb_output_vc_credit_ctrl;

    localparam int V  = 4;
    localparam int B  = 4;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [V-1:0]   req_in, req_out, grant, send_vc;
    logic           any_grant, credit_in_valid, send_valid, all_free, err;
    logic [1:0]     credit_in_vc;
    logic [V*CW-1:0] credit_cnt;

    output_vc_credit_ctrl #(.V(V), .B(B)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_in          (req_in),
        .req_out         (req_out),
        .grant           (grant),
        .any_grant       (any_grant),
        .credit_in_valid (credit_in_valid),
        .credit_in_vc    (credit_in_vc),
        .send_valid      (send_valid),
        .send_vc         (send_vc),
        .credit_cnt      (credit_cnt),
        .all_free        (all_free),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Model state: plain integer credit counts and expected registered outputs.
    int         m_cnt [V];
    bit         m_sv;
    logic [3:0] m_svc;
    bit         m_af;
    bit         m_err;
    bit         chk_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [11:0] all_four;
    logic [11:0] partial;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] model_packed();
        logic [11:0] r;
        for (int i = 0; i < V; i++) r[i*CW +: CW] = 3'(m_cnt[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < V; i++) m_cnt[i] = B;
        m_sv  = 1'b0;
        m_svc = '0;
        m_af  = 1'b1;
        m_err = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_ro;
        if (chk_en) begin
            for (int i = 0; i < V; i++) exp_ro[i] = req_in[i] && (m_cnt[i] != 0);
            check("req_out",    32'(req_out),    32'(exp_ro));
            check("send_valid", 32'(send_valid), 32'(m_sv));
            check("send_vc",    32'(send_vc),    32'(m_svc));
            check("credit_cnt", 32'(credit_cnt), 32'(model_packed()));
            check("all_free",   32'(all_free),   32'(m_af));
            check("err",        32'(err),        32'(m_err));
        end
    end

    // Apply one cycle of inputs (called at posedge+2), advance the model across the edge.
    task automatic step(input logic [3:0] rq, input logic ag, input logic [3:0] g,
                        input logic cv, input logic [1:0] vc);
        int         n [V];
        logic [3:0] ro;
        bit         ok, e, af;
        req_in = rq; any_grant = ag; grant = g; credit_in_valid = cv; credit_in_vc = vc;
        for (int i = 0; i < V; i++) ro[i] = rq[i] && (m_cnt[i] != 0);
        ok = ag && ($countones(g) == 1) && ((g & ro) != 0);
        e  = (ag && !ok) || (!ag && g != 0) || (cv && m_cnt[vc] == B);
        af = 1'b1;
        for (int i = 0; i < V; i++) begin
            n[i] = m_cnt[i] + ((cv && vc == i) ? 1 : 0) - ((ok && g[i]) ? 1 : 0);
            if (n[i] > B) n[i] = B;
            if (n[i] != B) af = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < V; i++) m_cnt[i] = n[i];
        m_sv  = ok;
        m_svc = ok ? g : 4'b0;
        m_af  = af;
        m_err = m_err | e;
        #1;
    endtask

    task automatic idle();
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        all_four = {3'd4, 3'd4, 3'd4, 3'd4};
        partial  = {3'd4, 3'd3, 3'd2, 3'd1};
        reset = 1'b0;
        req_in = '0; grant = '0; any_grant = 1'b0; credit_in_valid = 1'b0; credit_in_vc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b1;
        chk_en = 1'b1;

        // Reset / idle
        req_in = 4'b1111;
        #1;
        check("idle_req_out",    32'(req_out),    32'h0000000f);
        check("idle_credit_cnt", 32'(credit_cnt), 32'(all_four));
        check("idle_all_free",   32'(all_free),   32'd1);
        check("idle_err",        32'(err),        32'd0);
        check("idle_send_valid", 32'(send_valid), 32'd0);

        // Drain VC2
        for (int k = 0; k < 4; k++) begin
            step(4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0);
            check("drain_cnt2",       32'(credit_cnt[8:6]), 32'(3 - k));
            check("drain_send_valid", 32'(send_valid),      32'd1);
            check("drain_send_vc",    32'(send_vc),         32'h4);
        end
        check("drain_req_out2", 32'(req_out[2]), 32'd0);
        check("drain_all_free", 32'(all_free),   32'd0);
        idle();
        check("drain_idle_send", 32'(send_valid), 32'd0);

        // Simultaneous grant and credit
        do_reset();
        step(4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
        step(4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
        step(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        check("simul_cnt1",       32'(credit_cnt[5:3]), 32'd2);
        check("simul_send_valid", 32'(send_valid),      32'd1);
        check("simul_err0",       32'(err),             32'd0);
        step(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd3);
        check("simul_cnt0", 32'(credit_cnt[2:0]),  32'd3);
        check("simul_cnt3", 32'(credit_cnt[11:9]), 32'd4);
        check("simul_err1", 32'(err),              32'd1);

        // Bad (non-one-hot) grant
        do_reset();
        step(4'b1111, 1'b1, 4'b0011, 1'b0, 2'd0);
        check("bad_cnt",        32'(credit_cnt), 32'(all_four));
        check("bad_send_valid", 32'(send_valid), 32'd0);
        check("bad_err",        32'(err),        32'd1);
        repeat (10) idle();
        check("bad_err_sticky", 32'(err), 32'd1);

        // Grant on a zero-credit VC
        do_reset();
        repeat (4) step(4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
        check("zc_err_before", 32'(err), 32'd0);
        step(4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
        check("zc_cnt0",       32'(credit_cnt[2:0]), 32'd0);
        check("zc_send_valid", 32'(send_valid),      32'd0);
        check("zc_err",        32'(err),             32'd1);

        // Reset mid-operation
        do_reset();
        repeat (3) step(4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
        repeat (2) step(4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
        step(4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0);
        check("mid_counts", 32'(credit_cnt), 32'(partial));
        check("mid_send",   32'(send_valid), 32'd1);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_counts",     32'(credit_cnt), 32'(all_four));
        check("rst_send_valid", 32'(send_valid), 32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_all_free",   32'(all_free),   32'd1);
        reset = 1'b1;

        // Randomized traffic; odd rounds inject protocol errors.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                logic [3:0] rq, g, elig;
                logic       ag, cv;
                logic [1:0] vc;
                int         pick;
                rq = 4'($urandom);
                for (int i = 0; i < V; i++) elig[i] = rq[i] && (m_cnt[i] != 0);
                g  = '0;
                ag = 1'b0;
                if (elig != 0 && ($urandom_range(3) != 0)) begin
                    do pick = $urandom_range(V - 1); while (!elig[pick]);
                    g[pick] = 1'b1;
                    ag      = 1'b1;
                end
                cv = 1'b0;
                vc = 2'($urandom);
                if ($urandom_range(1) == 1) begin
                    for (int t = 0; t < 8; t++) begin
                        if (m_cnt[vc] < B) begin
                            cv = 1'b1;
                            break;
                        end
                        vc = 2'($urandom);
                    end
                end
                if ((round % 2 == 1) && ($urandom_range(99) < 3)) begin
                    g  = 4'($urandom);
                    ag = 1'($urandom);
                    cv = 1'b1;
                end
                step(rq, ag, g, cv, vc);
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/output_vc_credit_ctrl.md
# output_vc_credit_ctrl

Per-output-port credit controller for the VC-based mesh router. It tracks the free buffer slots (credits) of each downstream virtual channel and masks raw VC requests so the one-hot arbiter only sees requests that can be served. It consumes the arbiter's one-hot grant to spend credits and issue a registered send strobe to the crossbar. It also accepts credit returns from the downstream router.

## Interface
- `V`, default 4: number of virtual channels per port; this is the arbiter width.
- `B`, default 4: buffer depth per downstream VC, in flits; this is the credit ceiling.
- `CW`, derived, equals `$clog2(B+1)`: credit counter width. Not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_in`  in  V  raw requests; bit i means a flit is waiting for downstream VC i.
- `req_out`  out  V  masked requests to the arbiter `request` input.
- `grant`  in  V  one-hot grant from the arbiter.
- `any_grant`  in  1  arbiter any-grant.
- `credit_in_valid`  in  1  one-cycle credit return from downstream.
- `credit_in_vc`  in  `$clog2(V)`  binary VC index of the returned credit.
- `send_valid`  out  1  registered strobe: one flit is leaving this cycle.
- `send_vc`  out  V  registered one-hot VC of the departing flit.
- `credit_cnt`  out  V*CW  flattened counters; VC i occupies bits `[i*CW +: CW]`.
- `all_free`  out  1  every counter equals B (downstream fully drained).
- `err`  out  1  sticky protocol-error flag.

## Operation
- One counter `cnt[i]` per VC, range 0..B.
- `req_out[i] = req_in[i] & (cnt[i] != 0)`. This is purely combinational from registered counts.
- A grant is **accepted** when `any_grant=1` and `grant` is one-hot with bit i set, `req_out[i]=1`.
- On an accepted grant, `cnt[i]` decrements on the next edge.
- On `credit_in_valid`, `cnt[credit_in_vc]` increments on the next edge.
- Simultaneous accepted grant and credit return on the same VC leave `cnt` unchanged.
- On different VCs, both updates apply in the same cycle.
- `err` is set, and stays set until reset, on any of these events:
  - A credit return to a counter already at B (overflow). The counter holds at B; no wrap.
  - `any_grant=1` with `grant` not one-hot, or zero.
  - `any_grant=1` with the granted bit's `req_out=0`, i.e. zero credits or no request.
  - `any_grant=0` with `grant` nonzero.
  - `credit_in_vc >= V` while `credit_in_valid=1`.
- Any erroneous grant is ignored: no decrement and no send. A valid credit return in the same cycle still applies.
- A counter never underflows; decrements are only possible through `req_out`, which requires `cnt != 0`.
- `all_free` is registered. It is computed from next-state counts, so it is valid in the same cycle as the counts it describes.

## Timing
- Reset (`reset=0`, asynchronous): all `cnt` = B, `send_valid`=0, `send_vc`=0, `err`=0, `all_free`=1.
  - `req_out` follows `req_in` once reset is released, because all counts equal B.
- Grant at edge N → `send_valid`=1 and `send_vc`=grant during cycle N+1 (1-cycle latency). Counter is updated at edge N as well.
- Back-to-back grants to one VC are allowed every cycle while `cnt>0`.
  - With `cnt=1`, the grant at cycle N makes `req_out[i]=0` from cycle N+1. This prevents a double spend.
- Credit return at edge N → counter and `req_out` reflect it in cycle N+1. Minimum credit round trip inside the block is 1 cycle.
- Reset asserted mid-operation clears counts to B immediately, regardless of in-flight flits. `send_valid` drops asynchronously.
- No combinational path from `grant` or `credit_in_*` to `req_out`. `req_out` depends only on `req_in` and registers.

## Test plan
- **Reset/idle:** release reset, `req_in`=4'b1111 → `req_out`=4'b1111, all `credit_cnt`=4, `all_free`=1, `err`=0, `send_valid`=0.
- **Drain:** grant VC2 on four consecutive cycles with `req_in[2]`=1 → `send_valid`/`send_vc`=4'b0100 in cycles 1..4 after each grant. `cnt[2]` goes 3,2,1,0. `req_out[2]`=0 after the fourth grant. `all_free`=0.
- **Simultaneous:** with `cnt[1]`=2, grant VC1 and return credit VC1 in the same cycle → `cnt[1]` stays 2. Then grant VC0 and return credit VC3 in one cycle → `cnt[0]`=3, `cnt[3]` unchanged at 4 is overflow → `err`=1 and `cnt[3]`=4.
- **Bad grant:** `any_grant`=1 with `grant`=4'b0011 → no counter change, `send_valid`=0 next cycle, `err`=1 sticky through 10 idle cycles.
- **Zero-credit grant:** drain VC0 to 0, force `grant`=4'b0001 with `any_grant`=1 → `cnt[0]` stays 0, no send, `err`=1.
- **Reset mid-operation:** after partial drain (counts 1,2,3,4), assert `reset` between edges → counts read 4 immediately, `send_valid`=0, `err`=0, `all_free`=1.
